traffic_timer_fsm: RTL and testbench

TRAFFIC_TIMER_FSM -- requirements
Module: traffic_timer_fsm

---
 rtl/traffic_timer_fsm.sv | 176 +++++++++++++++++
 tb/tb_traffic_timer_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_timer_fsm.sv
// Red/green/yellow phase timer advanced by rising edges of a 1 s op_clk strobe.
// Define TRAFFIC_PED_REQ_EN to add the ped_btn port that shortens a pending green.
module traffic_timer_fsm #(
    parameter int GREEN_S   = 30,
    parameter int YELLOW_S  = 5,
    parameter int RED_S     = 25,
    parameter int PED_MIN_S = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_clk,
    input  logic       pause,
`ifdef TRAFFIC_PED_REQ_EN
    input  logic       ped_btn,
`endif
    output logic [2:0] light,
    output logic [5:0] remaining,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       ped_walk
);

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_e;

    // Packs {tens, ones}; five subtractions suffice because the count never exceeds 59.
    function automatic logic [7:0] to_bcd(input logic [5:0] value);
        logic [3:0] tens;
        logic [5:0] rest;
        tens = 4'd0;
        rest = value;
        for (int i = 0; i < 5; i++) begin
            if (rest >= 6'd10) begin
                rest = rest - 6'd10;
                tens = tens + 4'd1;
            end else begin
                rest = rest;
            end
        end
        return {tens, rest[3:0]};
    endfunction

    function automatic logic [2:0] light_of(input state_e st);
        case (st)
            ST_RED:    return 3'b100;
            ST_GREEN:  return 3'b001;
            ST_YELLOW: return 3'b010;
            default:   return 3'b100;
        endcase
    endfunction

    localparam logic [5:0] RED_D    = 6'(RED_S);
    localparam logic [5:0] GREEN_D  = 6'(GREEN_S);
    localparam logic [5:0] YELLOW_D = 6'(YELLOW_S);
    localparam logic [5:0] PED_D    = 6'(PED_MIN_S);
    localparam logic [7:0] RED_BCD  = to_bcd(RED_D);

    state_e     state_q, state_d;
    logic [5:0] rem_q, rem_d;
    logic [2:0] light_q, light_d;
    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic       walk_q, walk_d;
    logic       op_q;
    logic       tick_s, illegal_s, ped_pend_s, ped_short_s;
    logic [7:0] bcd_s;

    assign tick_s      = op_clk & ~op_q;
    assign illegal_s   = (state_q == 2'd3) || (light_q != light_of(state_q)) ||
                         (rem_q == 6'd0) || (rem_q > 6'd59);
    assign ped_short_s = ped_pend_s && (state_q == ST_GREEN) && (rem_q > PED_D);

`ifdef TRAFFIC_PED_REQ_EN
    logic ped_pend_q, ped_pend_d;

    // Sticky request; entering yellow retires it, though a press on that same edge still counts.
    always_comb begin
        ped_pend_d = ped_pend_q | ped_btn;
        if ((state_d == ST_YELLOW) && (state_q != ST_YELLOW)) begin
            ped_pend_d = ped_btn;
        end else begin
            ped_pend_d = ped_pend_q | ped_btn;
        end
    end

    // Pedestrian request register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    assign ped_pend_s = ped_pend_q;
`else
    assign ped_pend_s = 1'b0;
`endif

    // State, count and registered outputs; a paused tick is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 1'b1;
            state_q <= ST_RED;
            rem_q   <= RED_D;
            light_q <= 3'b100;
            tens_q  <= RED_BCD[7:4];
            ones_q  <= RED_BCD[3:0];
            walk_q  <= 1'b1;
        end else begin
            op_q    <= op_clk;
            state_q <= state_d;
            rem_q   <= rem_d;
            light_q <= light_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            walk_q  <= walk_d;
        end
    end

    // Next-state and countdown logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (illegal_s) begin
            state_d = ST_RED;
            rem_d   = RED_D;
        end else if (tick_s && !pause) begin
            if (rem_q == 6'd1) begin
                case (state_q)
                    ST_RED: begin
                        state_d = ST_GREEN;
                        rem_d   = GREEN_D;
                    end
                    ST_GREEN: begin
                        state_d = ST_YELLOW;
                        rem_d   = YELLOW_D;
                    end
                    ST_YELLOW: begin
                        state_d = ST_RED;
                        rem_d   = RED_D;
                    end
                    default: begin
                        state_d = ST_RED;
                        rem_d   = RED_D;
                    end
                endcase
            end else if (ped_short_s) begin
                rem_d = PED_D;
            end else begin
                rem_d = rem_q - 6'd1;
            end
        end else begin
            state_d = state_q;
            rem_d   = rem_q;
        end
    end

    // Outputs decoded from the next state so they land on the same edge as the update.
    always_comb begin
        bcd_s   = to_bcd(rem_d);
        light_d = light_of(state_d);
        tens_d  = bcd_s[7:4];
        ones_d  = bcd_s[3:0];
        walk_d  = (state_d == ST_RED);
    end

    assign light     = light_q;
    assign remaining = rem_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign ped_walk  = walk_q;

endmodule

// File: tb/tb_traffic_timer_fsm.sv
// Randomised bench for traffic_timer_fsm against a phase/duration reference model;
// a second instance with a 12 s red phase exercises two-digit BCD.
module tb_traffic_timer_fsm;

    localparam int PED_MIN = 2;
`ifdef TRAFFIC_PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       op_clk  = 1'b1;
    logic       pause   = 1'b0;
    logic       ped_btn = 1'b0;
    logic [2:0] light_a, light_b;
    logic [5:0] rem_a, rem_b;
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
    logic       walk_a, walk_b;

    always #5 clk = ~clk;

    traffic_timer_fsm #(.GREEN_S(6), .YELLOW_S(2), .RED_S(3), .PED_MIN_S(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .op_clk(op_clk), .pause(pause),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_btn(ped_btn),
`endif
        .light(light_a), .remaining(rem_a), .bcd_tens(tens_a), .bcd_ones(ones_a),
        .ped_walk(walk_a)
    );

    traffic_timer_fsm #(.GREEN_S(6), .YELLOW_S(2), .RED_S(12), .PED_MIN_S(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .op_clk(op_clk), .pause(pause),
`ifdef TRAFFIC_PED_REQ_EN
        .ped_btn(ped_btn),
`endif
        .light(light_b), .remaining(rem_b), .bcd_tens(tens_b), .bcd_ones(ones_b),
        .ped_walk(walk_b)
    );

    // Reference model: phase 0=red, 1=green, 2=yellow, one entry per instance.
    int dur [2][3] = '{'{3, 6, 2}, '{12, 6, 2}};
    int m_ph [2];
    int m_rem [2];
    bit m_pend [2];
    bit m_op;
    bit m_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int op_cnt   = 0;
    int op_half  = 10;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_light(input int ph);
        return (ph == 0) ? 4 : ((ph == 1) ? 1 : 2);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d]   = 0;
            m_rem[d]  = dur[d][0];
            m_pend[d] = 1'b0;
        end
        m_op = 1'b1;
    endtask

    task automatic model_edge();
        m_tick = op_clk && !m_op;
        m_op   = op_clk;
        for (int d = 0; d < 2; d++) begin
            bit ent;
            ent = 1'b0;
            if (m_tick && !pause) begin
                if (m_rem[d] == 1) begin
                    m_ph[d]  = (m_ph[d] + 1) % 3;
                    m_rem[d] = dur[d][m_ph[d]];
                    ent      = (m_ph[d] == 2);
                end else if (PED_EN && m_pend[d] && m_ph[d] == 1 && m_rem[d] > PED_MIN) begin
                    m_rem[d] = PED_MIN;
                end else begin
                    m_rem[d] = m_rem[d] - 1;
                end
            end
            if (PED_EN) m_pend[d] = (ent ? 1'b0 : m_pend[d]) | ped_btn;
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [2:0] lt;
            logic [5:0] rm;
            logic [3:0] tn, on;
            logic       wk;
            lt = (d == 0) ? light_a : light_b;
            rm = (d == 0) ? rem_a   : rem_b;
            tn = (d == 0) ? tens_a  : tens_b;
            on = (d == 0) ? ones_a  : ones_b;
            wk = (d == 0) ? walk_a  : walk_b;
            check($sformatf("light%0d", d), lt, exp_light(m_ph[d]));
            check($sformatf("remaining%0d", d), rm, m_rem[d]);
            check($sformatf("bcd_tens%0d", d), tn, m_rem[d] / 10);
            check($sformatf("bcd_ones%0d", d), on, m_rem[d] % 10);
            check($sformatf("ped_walk%0d", d), wk, m_ph[d] == 0);
        end
    endtask

    // One clock: advance the op_clk square wave, take the edge, then check #1 after it.
    task automatic step();
        op_cnt++;
        if (op_cnt >= op_half) begin
            op_clk = ~op_clk;
            op_cnt = 0;
        end
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            got = m_tick && !pause;
        end
        check("tick_timeout", got, 1);
    endtask

    task automatic wait_state(input int lt, input int rm);
        for (int i = 0; i < 30 && !(light_a == lt[2:0] && rem_a == rm[5:0]); i++) wait_tick();
        check("reach_state", {light_a, rem_a}, {lt[2:0], rm[5:0]});
    endtask

    int exp_seq [11] = '{2, 1, 6, 5, 4, 3, 2, 1, 2, 1, 3};
    int exp_lt  [11] = '{4, 4, 1, 1, 1, 1, 1, 1, 2, 2, 4};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_light", light_a, 3'b100);
        check("rst_remaining", rem_a, 3);
        check("rst_bcd", {tens_a, ones_a}, 8'h03);
        check("rst_walk", walk_a, 1);
        check("rst_bcd_12", {tens_b, ones_b}, 8'h12);
        rst_n = 1'b1;

        // Release with op_clk high: nothing moves before the first rising edge.
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_spurious_tick", {light_a, rem_a}, {3'b100, 6'd3});
        end

        for (int i = 0; i < 11; i++) begin
            wait_tick();
            check($sformatf("seq_rem_t%0d", i + 1), rem_a, exp_seq[i]);
            check($sformatf("seq_light_t%0d", i + 1), light_a, exp_lt[i]);
            if (i == 0) check("bcd_11", {tens_b, ones_b}, 8'h11);
        end

        wait_state(1, 5);
        pause = 1'b1;
        repeat (45) step();
        check("pause_hold", rem_a, 5);
        pause = 1'b0;
        wait_tick();
        check("pause_resume", rem_a, 4);

`ifdef TRAFFIC_PED_REQ_EN
        wait_state(1, 6);
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        wait_tick();
        check("ped_short", rem_a, 2);
        wait_tick();
        check("ped_short_1", rem_a, 1);
        wait_tick();
        check("ped_yellow", light_a, 3'b010);
        wait_state(1, 6);
        wait_tick();
        check("ped_cleared", rem_a, 5);
        wait_state(1, 2);
        ped_btn = 1'b1;
        step();
        ped_btn = 1'b0;
        wait_tick();
        check("ped_late_1", rem_a, 1);
        wait_tick();
        check("ped_late_yellow", light_a, 3'b010);
`endif

        for (int c = 0; c < 3000; c++) begin
            pause   = ($urandom_range(7) == 0);
            ped_btn = ($urandom_range(15) == 0);
            if (op_cnt == 0) op_half = $urandom_range(12, 4);
            if ($urandom_range(799) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        pause   = 1'b0;
        ped_btn = 1'b0;

        // Reset in yellow takes effect without waiting for a clock edge.
        for (int i = 0; i < 30 && light_a != 3'b010; i++) wait_tick();
        check("yellow_reached", light_a, 3'b010);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_light", light_a, 3'b100);
        check("async_rst_remaining", rem_a, 3);
        check("async_rst_remaining_12", rem_b, 12);
        step();
        rst_n = 1'b1;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
